// File: rtl/l1c_pkg.sv
// ============================================================================
// Module      : l1c_pkg
// Description : Shared types and address-field width helpers for the L1
//               write-back data cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package l1c_pkg;

  // Miss-handling controller states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOOKUP    = 2'd1,
    WRITEBACK = 2'd2,
    REFILL    = 2'd3
  } state_t;

  // Performance counters saturate at this width
  localparam int L1C_CNT_WIDTH = 32;

  // Byte-in-word offset bits
  function automatic int l1c_byte_bits(input int dw);
    return $clog2(dw / 8);
  endfunction

  // Full line offset bits (byte-in-word plus word-in-line)
  function automatic int l1c_off_bits(input int dw, input int wpl);
    return $clog2(dw / 8) + $clog2(wpl);
  endfunction

  // Set index bits
  function automatic int l1c_idx_bits(input int sets);
    return $clog2(sets);
  endfunction

  // Tag bits: whatever the offset and index leave over
  function automatic int l1c_tag_bits(input int aw, input int dw, input int wpl, input int sets);
    return aw - l1c_off_bits(dw, wpl) - l1c_idx_bits(sets);
  endfunction

endpackage

`default_nettype wire

// File: rtl/l1c_lru.sv
// ============================================================================
// Module      : l1c_lru
// Description : Per-set age-based LRU tracker. The accessed way becomes the
//               youngest (NUM_WAYS-1); ways younger than its old age shift
//               down by one. The victim is the lowest way with age 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1c_lru #(
  parameter int NUM_SETS = 64,
  parameter int NUM_WAYS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [$clog2(NUM_SETS)-1:0] i_index,
  input  logic [$clog2(NUM_WAYS)-1:0] i_access_way,
  input  logic                        i_access_en,
  output logic [$clog2(NUM_WAYS)-1:0] o_victim_way
);

  localparam int WAY_BITS = $clog2(NUM_WAYS);

  logic [WAY_BITS-1:0] r_age [NUM_SETS][NUM_WAYS];
  logic                w_found;

  // Age update on every cache hit; all ages cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          r_age[s][w] <= '0;
        end
      end
    end else if (i_access_en) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_BITS'(w) == i_access_way) begin
          r_age[i_index][w] <= WAY_BITS'(NUM_WAYS - 1);
        end else if (r_age[i_index][w] > r_age[i_index][i_access_way]) begin
          r_age[i_index][w] <= r_age[i_index][w] - WAY_BITS'(1);
        end
      end
    end
  end

  // Oldest way of the addressed set (lowest index wins a tie)
  always_comb begin
    o_victim_way = '0;
    w_found      = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!w_found && (r_age[i_index][w] == '0)) begin
        o_victim_way = WAY_BITS'(w);
        w_found      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/l1_dcache_wb.sv
// ============================================================================
// Module      : l1_dcache_wb
// Description : Set-associative write-back / write-allocate L1 data cache
//               with multi-word lines, age-based LRU replacement and a
//               burst refill/eviction memory port.
//               Optional macro L1C_PERF_CNT_EN adds saturating hit, miss and
//               writeback counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1_dcache_wb
  import l1c_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int NUM_SETS       = 64,
  parameter int NUM_WAYS       = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_valid_i,
  output logic                    cpu_ready_o,
  input  logic                    cpu_we_i,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cpu_be_i,
  output logic                    cpu_rvalid_o,
  output logic [DATA_WIDTH-1:0]   cpu_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_ready_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
`ifdef L1C_PERF_CNT_EN
  ,
  output logic [L1C_CNT_WIDTH-1:0] hit_cnt_o,
  output logic [L1C_CNT_WIDTH-1:0] miss_cnt_o,
  output logic [L1C_CNT_WIDTH-1:0] wb_cnt_o
`endif
);

  localparam int BYTE_BITS = l1c_byte_bits(DATA_WIDTH);
  localparam int WORD_BITS = $clog2(WORDS_PER_LINE);
  localparam int OFF_BITS  = l1c_off_bits(DATA_WIDTH, WORDS_PER_LINE);
  localparam int IDX_BITS  = l1c_idx_bits(NUM_SETS);
  localparam int TAG_BITS  = l1c_tag_bits(ADDR_WIDTH, DATA_WIDTH, WORDS_PER_LINE, NUM_SETS);
  localparam int WAY_BITS  = $clog2(NUM_WAYS);
  localparam int BE_W      = DATA_WIDTH / 8;

  // Storage arrays
  logic                  r_valid [NUM_SETS][NUM_WAYS];
  logic                  r_dirty [NUM_SETS][NUM_WAYS];
  logic [TAG_BITS-1:0]   r_tag   [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0] r_data  [NUM_SETS][NUM_WAYS][WORDS_PER_LINE];

  // Controller state and captured request
  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [BE_W-1:0]       r_be;
  logic [WORD_BITS-1:0]  r_beat;
  logic                  r_wait;
  logic                  r_replay;
  logic [WAY_BITS-1:0]   r_victim;
  logic [TAG_BITS-1:0]   r_victim_tag;

  logic [TAG_BITS-1:0]   w_tag;
  logic [IDX_BITS-1:0]   w_index;
  logic [WORD_BITS-1:0]  w_word;
  logic                  w_hit;
  logic [WAY_BITS-1:0]   w_hit_way;
  logic [WAY_BITS-1:0]   w_lru_victim;
  logic [WAY_BITS-1:0]   w_victim;
  logic                  w_inv_found;
  logic                  w_lookup_hit;
  logic                  w_lookup_miss;
  logic                  w_refill_done;
  logic                  w_wb_done;
  logic                  w_unused;

  assign w_tag    = r_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign w_index  = r_addr[OFF_BITS +: IDX_BITS];
  assign w_word   = r_addr[BYTE_BITS +: WORD_BITS];
  assign w_unused = ^r_addr[BYTE_BITS-1:0];

  assign w_lookup_hit  = (r_state == LOOKUP) && w_hit;
  assign w_lookup_miss = (r_state == LOOKUP) && !w_hit;
  assign w_refill_done = (r_state == REFILL) && r_wait && mem_rvalid_i && (&r_beat);
  assign w_wb_done     = (r_state == WRITEBACK) && mem_ready_i && (&r_beat);

  // Tag compare across the ways of the addressed set
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!w_hit && r_valid[w_index][w] && (r_tag[w_index][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_BITS'(w);
      end
    end
  end

  // Victim: lowest invalid way, otherwise the LRU choice
  always_comb begin
    w_victim    = w_lru_victim;
    w_inv_found = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!w_inv_found && !r_valid[w_index][w]) begin
        w_victim    = WAY_BITS'(w);
        w_inv_found = 1'b1;
      end
    end
  end

  l1c_lru #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS)
  ) u_lru (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_index      (w_index),
    .i_access_way (w_hit_way),
    .i_access_en  (w_lookup_hit),
    .o_victim_way (w_lru_victim)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and all CPU/memory outputs; outputs decode from state so reset drops them at once
  always_comb begin
    w_next       = r_state;
    cpu_ready_o  = 1'b0;
    cpu_rvalid_o = 1'b0;
    cpu_rdata_o  = '0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    case (r_state)
      IDLE: begin
        cpu_ready_o = 1'b1;
        if (cpu_valid_i) begin
          w_next = LOOKUP;
        end
      end
      LOOKUP: begin
        if (w_hit) begin
          cpu_rvalid_o = 1'b1;
          cpu_rdata_o  = r_data[w_index][w_hit_way][w_word];
          w_next       = IDLE;
        end else if (r_valid[w_index][w_victim] && r_dirty[w_index][w_victim]) begin
          w_next = WRITEBACK;
        end else begin
          w_next = REFILL;
        end
      end
      WRITEBACK: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {r_victim_tag, w_index, r_beat, {BYTE_BITS{1'b0}}};
        mem_wdata_o = r_data[w_index][r_victim][r_beat];
        if (w_wb_done) begin
          w_next = REFILL;
        end
      end
      REFILL: begin
        if (!r_wait) begin
          mem_req_o  = 1'b1;
          mem_addr_o = {w_tag, w_index, r_beat, {BYTE_BITS{1'b0}}};
        end
        if (w_refill_done) begin
          w_next = LOOKUP;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Request capture, victim latch, beat counter and refill handshake phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_beat       <= '0;
      r_wait       <= 1'b0;
      r_replay     <= 1'b0;
      r_victim     <= '0;
      r_victim_tag <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cpu_valid_i) begin
            r_addr   <= cpu_addr_i;
            r_we     <= cpu_we_i;
            r_wdata  <= cpu_wdata_i;
            r_be     <= cpu_be_i;
            r_replay <= 1'b0;
          end
        end
        LOOKUP: begin
          if (!w_hit) begin
            r_victim     <= w_victim;
            r_victim_tag <= r_tag[w_index][w_victim];
            r_beat       <= '0;
            r_wait       <= 1'b0;
          end
        end
        WRITEBACK: begin
          if (mem_ready_i) begin
            r_beat <= r_beat + WORD_BITS'(1);
          end
        end
        REFILL: begin
          if (!r_wait) begin
            if (mem_ready_i) begin
              r_wait <= 1'b1;
            end
          end else if (mem_rvalid_i) begin
            r_wait <= 1'b0;
            r_beat <= r_beat + WORD_BITS'(1);
            if (&r_beat) begin
              r_replay <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Line state: a missing victim is invalidated until its refill completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
        end
      end
    end else begin
      if (w_lookup_miss) begin
        r_valid[w_index][w_victim] <= 1'b0;
        r_dirty[w_index][w_victim] <= 1'b0;
      end
      if (w_lookup_hit && r_we) begin
        r_dirty[w_index][w_hit_way] <= 1'b1;
      end
      if (w_refill_done) begin
        r_valid[w_index][r_victim] <= 1'b1;
        r_dirty[w_index][r_victim] <= 1'b0;
      end
    end
  end

  // Tag and data storage (no reset: contents are qualified by the valid bits)
  always_ff @(posedge clk) begin
    if (w_lookup_hit && r_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (r_be[b]) begin
          r_data[w_index][w_hit_way][w_word][b*8 +: 8] <= r_wdata[b*8 +: 8];
        end
      end
    end
    if ((r_state == REFILL) && r_wait && mem_rvalid_i) begin
      r_data[w_index][r_victim][r_beat] <= mem_rdata_i;
    end
    if (w_refill_done) begin
      r_tag[w_index][r_victim] <= w_tag;
    end
  end

`ifdef L1C_PERF_CNT_EN
  // Saturating event counters; replayed lookups after a refill do not count as hits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      wb_cnt_o   <= '0;
    end else begin
      if (w_lookup_hit && !r_replay && (hit_cnt_o != '1)) begin
        hit_cnt_o <= hit_cnt_o + L1C_CNT_WIDTH'(1);
      end
      if (w_lookup_miss && (miss_cnt_o != '1)) begin
        miss_cnt_o <= miss_cnt_o + L1C_CNT_WIDTH'(1);
      end
      if (w_wb_done && (wb_cnt_o != '1)) begin
        wb_cnt_o <= wb_cnt_o + L1C_CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_l1_dcache_wb.sv
// ============================================================================
// Module      : tb_l1_dcache_wb
// Description : Self-checking bench for l1_dcache_wb. A recency-ordered line
//               list plus a sparse backing store predicts every memory beat
//               and every load result; a single negedge process answers the
//               memory port and compares the DUT against those predictions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l1_dcache_wb;

  logic        clk;
  logic        rst_n;
  logic        cpu_valid_i;
  logic        cpu_ready_o;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic [3:0]  cpu_be_i;
  logic        cpu_rvalid_o;
  logic [31:0] cpu_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  l1_dcache_wb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_valid_i  (cpu_valid_i),
    .cpu_ready_o  (cpu_ready_o),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_be_i     (cpu_be_i),
    .cpu_rvalid_o (cpu_rvalid_o),
    .cpu_rdata_o  (cpu_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ready_i  (mem_ready_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]       set;
    logic [21:0]      tag;
    bit               dirty;
    logic [3:0][31:0] data;
  } line_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    bit          is_load;
    logic [31:0] data;
  } resp_t;

  line_t       cache_q[$];      // most recently used at the back
  beat_t       exp_beats[$];
  resp_t       exp_resp[$];
  logic [31:0] mem [logic [31:0]];

  int n_tests = 0;
  int n_fail  = 0;
  int stall_cnt = 0;
  int stalled_seen = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  // Cache model: predicts hit/miss, beats, and load data
  task automatic model_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, output bit hit);
    logic [5:0]  set;
    logic [21:0] tag;
    int          w;
    int          pos;
    int          cnt;
    int          first;
    line_t       ln;
    line_t       ev;
    logic [31:0] a;
    resp_t       r;
    set = addr[9:4];
    tag = addr[31:10];
    w   = int'(addr[3:2]);
    pos = -1;
    for (int i = 0; i < cache_q.size(); i++)
      if (cache_q[i].set == set && cache_q[i].tag == tag) pos = i;
    if (pos >= 0) begin
      hit = 1'b1;
      ln  = cache_q[pos];
      cache_q.delete(pos);
    end else begin
      hit   = 1'b0;
      cnt   = 0;
      first = -1;
      for (int i = 0; i < cache_q.size(); i++) begin
        if (cache_q[i].set == set) begin
          cnt++;
          if (first < 0) first = i;
        end
      end
      if (cnt == 4) begin
        ev = cache_q[first];
        cache_q.delete(first);
        if (ev.dirty) begin
          for (int k = 0; k < 4; k++) begin
            a = {ev.tag, set, 2'(k), 2'b00};
            exp_beats.push_back('{we: 1'b1, addr: a, wdata: ev.data[k]});
            mem[a] = ev.data[k];
          end
        end
      end
      ln.set   = set;
      ln.tag   = tag;
      ln.dirty = 1'b0;
      for (int k = 0; k < 4; k++) begin
        a = {tag, set, 2'(k), 2'b00};
        exp_beats.push_back('{we: 1'b0, addr: a, wdata: 32'h0});
        ln.data[k] = mem_rd(a);
      end
    end
    r.is_load = !we;
    r.data    = ln.data[w];
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ln.data[w][b*8 +: 8] = wdata[b*8 +: 8];
      ln.dirty = 1'b1;
    end
    cache_q.push_back(ln);
    exp_resp.push_back(r);
  endtask

  // Memory responder and the single DUT-vs-model compare process
  initial begin
    bit          rd_pending;
    logic [31:0] rd_addr;
    beat_t       b;
    resp_t       r;
    rd_pending   = 1'b0;
    rd_addr      = '0;
    mem_ready_i  = 1'b1;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      if (!rst_n) begin
        rd_pending  = 1'b0;
        mem_ready_i = 1'b1;
        continue;
      end
      if (rd_pending) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem_rd(rd_addr);
        rd_pending   = 1'b0;
      end
      if (cpu_rvalid_o) begin
        if (exp_resp.size() == 0) begin
          chk("unexpected_cpu_rvalid", 32'(cpu_rvalid_o), 32'h0);
        end else begin
          r = exp_resp.pop_front();
          if (r.is_load) chk("load_data", cpu_rdata_o, r.data);
        end
      end
      if (mem_req_o) begin
        if (stall_cnt > 0) begin
          mem_ready_i = 1'b0;
          stall_cnt--;
          stalled_seen++;
        end else begin
          mem_ready_i = 1'b1;
        end
        if (exp_beats.size() == 0) begin
          chk("unexpected_mem_req", 32'(mem_req_o), 32'h0);
        end else begin
          b = exp_beats[0];
          chk("mem_we", 32'(mem_we_o), 32'(b.we));
          chk("mem_addr", mem_addr_o, b.addr);
          if (b.we) chk("mem_wdata", mem_wdata_o, b.wdata);
          if (mem_ready_i) begin
            void'(exp_beats.pop_front());
            if (!b.we) begin
              rd_pending = 1'b1;
              rd_addr    = b.addr;
            end
          end
        end
      end else begin
        mem_ready_i = 1'b1;
      end
    end
  end

  // One CPU request: returns load data and latency in cycles after acceptance
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rd, output int lat);
    bit exp_hit;
    int g;
    model_access(we, addr, wdata, be, exp_hit);
    @(negedge clk);
    g = 0;
    while (!cpu_ready_o && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!cpu_ready_o) chk("cpu_ready_timeout", 32'(cpu_ready_o), 32'h1);
    cpu_valid_i = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
    cpu_be_i    = be;
    @(negedge clk);
    cpu_valid_i = 1'b0;
    lat = 1;
    while (!cpu_rvalid_o && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (!cpu_rvalid_o) chk("cpu_rvalid_timeout", 32'(cpu_rvalid_o), 32'h1);
    rd = cpu_rdata_o;
    chk("hit_latency_matches_model", 32'(lat == 1), 32'(exp_hit));
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    int          g;
    bit          eh;
    logic [31:0] tags [4];

    rst_n       = 1'b0;
    cpu_valid_i = 1'b0;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = '0;
    cpu_wdata_i = '0;
    cpu_be_i    = '0;
    mem[32'h100] = 32'h000000A0;
    mem[32'h104] = 32'h000000A1;
    mem[32'h108] = 32'h000000A2;
    mem[32'h10C] = 32'h000000A3;

    // Reset state
    #1;
    chk("rst_cpu_ready", 32'(cpu_ready_o), 32'h1);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid_o), 32'h0);
    chk("rst_cpu_rdata", cpu_rdata_o, 32'h0);
    chk("rst_mem_req", 32'(mem_req_o), 32'h0);
    chk("rst_mem_we", 32'(mem_we_o), 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Cold load, then byte-enable store merge and reload with no memory traffic
    access(1'b0, 32'h100, 32'h0, 4'h0, rd, lat);
    chk("cold_load_data", rd, 32'h000000A0);
    chk("cold_load_is_miss", 32'(lat > 1), 32'h1);
    access(1'b1, 32'h104, 32'hDEADBEEF, 4'b0011, rd, lat);
    chk("store_hit_latency", 32'(lat), 32'h1);
    access(1'b0, 32'h104, 32'h0, 4'h0, rd, lat);
    chk("merged_load_data", rd, 32'h0000BEEF);
    chk("merged_load_latency", 32'(lat), 32'h1);
    access(1'b0, 32'h10C, 32'h0, 4'h0, rd, lat);
    chk("last_word_data", rd, 32'h000000A3);

    // LRU: fill set 0, touch first line, fifth tag must evict the second
    tags = '{32'h000, 32'h400, 32'h800, 32'hC00};
    for (int i = 0; i < 4; i++) access(1'b0, tags[i], 32'h0, 4'h0, rd, lat);
    access(1'b0, 32'h000, 32'h0, 4'h0, rd, lat);
    chk("touch_way0_hit", 32'(lat), 32'h1);
    access(1'b0, 32'h1000, 32'h0, 4'h0, rd, lat);
    chk("fifth_tag_miss", 32'(lat > 1), 32'h1);
    access(1'b0, 32'h000, 32'h0, 4'h0, rd, lat);
    chk("way0_retained", 32'(lat), 32'h1);
    access(1'b0, 32'h400, 32'h0, 4'h0, rd, lat);
    chk("way1_evicted", 32'(lat > 1), 32'h1);

    // Dirty eviction with a stalled first write beat
    access(1'b1, 32'h020, 32'h11111111, 4'hF, rd, lat);
    access(1'b1, 32'h02C, 32'h44444444, 4'hF, rd, lat);
    access(1'b0, 32'h420, 32'h0, 4'h0, rd, lat);
    access(1'b0, 32'h820, 32'h0, 4'h0, rd, lat);
    access(1'b0, 32'hC20, 32'h0, 4'h0, rd, lat);
    stalled_seen = 0;
    stall_cnt    = 3;
    access(1'b0, 32'h1020, 32'h0, 4'h0, rd, lat);
    chk("stall_cycles", 32'(stalled_seen), 32'h3);
    access(1'b0, 32'h020, 32'h0, 4'h0, rd, lat);
    chk("written_back_word0", rd, 32'h11111111);
    chk("written_back_reload_miss", 32'(lat > 1), 32'h1);
    access(1'b0, 32'h02C, 32'h0, 4'h0, rd, lat);
    chk("written_back_word3", rd, 32'h44444444);

    // Reset during refill beat 2 aborts the burst and leaves the line invalid
    model_access(1'b0, 32'h3040, 32'h0, 4'h0, eh);
    @(negedge clk);
    cpu_valid_i = 1'b1;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = 32'h3040;
    @(negedge clk);
    cpu_valid_i = 1'b0;
    g = 0;
    while (!(mem_req_o && mem_addr_o == 32'h3048) && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("reached_refill_beat2", 32'(mem_req_o && mem_addr_o == 32'h3048), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_mem_req_drop", 32'(mem_req_o), 32'h0);
    chk("async_cpu_ready", 32'(cpu_ready_o), 32'h1);
    exp_beats.delete();
    exp_resp.delete();
    cache_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 32'h3040, 32'h0, 4'h0, rd, lat);
    chk("reload_after_reset_miss", 32'(lat > 1), 32'h1);
    chk("reload_after_reset_data", rd, {16'h3040 ^ 16'hC0DE, 16'h3040});
    access(1'b0, 32'h100, 32'h0, 4'h0, rd, lat);
    chk("old_line_lost_by_reset", 32'(lat > 1), 32'h1);

    repeat (4) @(negedge clk);
    chk("beats_outstanding", 32'(exp_beats.size()), 32'h0);
    chk("responses_outstanding", 32'(exp_resp.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
